traffic_light_multi: RTL and testbench

//  Parametrised N-approach intersection controller; successor to the 2-way N/E light controller.

---
 rtl/traffic_light_multi.sv | 137 +++++++++++++
 tb/tb_traffic_light_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_multi.sv
// N-approach intersection controller: round-robin green over approaches with latched demand,
// gap-out / max-out green extension, yellow and all-red clearance, all paced by the EN tick.
module traffic_light_multi #(
   parameter int NUM_DIR     = 4,
   parameter int CNT_W       = 8,
   parameter int T_MIN_GREEN = 20,
   parameter int T_MAX_GREEN = 60,
   parameter int T_YELLOW    = 5,
   parameter int T_ALLRED    = 2
) (
   input  logic                       clk,
   input  logic                       R,
   input  logic                       EN,
   input  logic [NUM_DIR-1:0]         C,
   output logic [NUM_DIR-1:0]         RED,
   output logic [NUM_DIR-1:0]         GRN,
   output logic [NUM_DIR-1:0]         YEL,
   output logic [$clog2(NUM_DIR)-1:0] PHASE
);

   localparam int PW = $clog2(NUM_DIR);

   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(T_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(T_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   timer_reg;
   logic [PW-1:0]      phase_reg;
   logic [PW-1:0]      nxt_reg;
   logic [NUM_DIR-1:0] dem_reg;
   logic [NUM_DIR-1:0] dem_next;

   logic [NUM_DIR-1:0] sel_phase;
   logic [CNT_W-1:0]   timer_inc;
   logic               other;
   logic               car_here;
   logic               enter_green;
   logic               green_exit;
   logic [PW-1:0]      nxt_pick;
   logic [NUM_DIR-1:0] grn_lamp;
   logic [NUM_DIR-1:0] yel_lamp;

   always_comb begin
      sel_phase   = NUM_DIR'(1) << phase_reg;
      timer_inc   = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + CNT_W'(1);
      other       = |(dem_reg & ~sel_phase);
      car_here    = |(C & sel_phase);
      enter_green = EN && (state_reg == ST_ALLRED) && (timer_reg == ALLRED_LAST);
      green_exit  = EN && (state_reg == ST_GREEN) && (timer_reg >= MIN_LAST) && other &&
                    (!car_here || (timer_reg >= MAX_LAST));
      grn_lamp    = (state_reg == ST_GREEN)  ? sel_phase : '0;
      yel_lamp    = (state_reg == ST_YELLOW) ? sel_phase : '0;
   end

   // Scan downwards so the nearest demanded approach after the current one wins.
   always_comb begin
      nxt_pick = phase_reg;
      for (int k = NUM_DIR - 1; k >= 1; k--) begin
         if (dem_reg[(int'(phase_reg) + k) % NUM_DIR]) begin
            nxt_pick = PW'((int'(phase_reg) + k) % NUM_DIR);
         end
      end
   end

   // The serving approach ignores its own sensor; entering green for an approach clears it.
   generate
      for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dem
         assign dem_next[gi] =
            (dem_reg[gi] | (C[gi] & ~((state_reg == ST_GREEN) && (phase_reg == PW'(gi)))))
            & ~(enter_green && (nxt_reg == PW'(gi)));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (R) begin
         state_reg <= ST_ALLRED;
         timer_reg <= '0;
         phase_reg <= '0;
         nxt_reg   <= '0;
         dem_reg   <= '0;
         RED       <= '1;
         GRN       <= '0;
         YEL       <= '0;
      end else begin
         dem_reg <= dem_next;
         GRN     <= grn_lamp;
         YEL     <= yel_lamp;
         RED     <= ~(grn_lamp | yel_lamp);
         if (EN) begin
            case (state_reg)
               ST_ALLRED: begin
                  if (timer_reg == ALLRED_LAST) begin
                     state_reg <= ST_GREEN;
                     timer_reg <= '0;
                     phase_reg <= nxt_reg;
                  end else begin
                     timer_reg <= timer_inc;
                  end
               end
               ST_GREEN: begin
                  if (green_exit) begin
                     state_reg <= ST_YELLOW;
                     timer_reg <= '0;
                     nxt_reg   <= nxt_pick;
                  end else begin
                     timer_reg <= timer_inc;
                  end
               end
               ST_YELLOW: begin
                  if (timer_reg == YEL_LAST) begin
                     state_reg <= ST_ALLRED;
                     timer_reg <= '0;
                  end else begin
                     timer_reg <= timer_inc;
                  end
               end
               default: begin
                  state_reg <= ST_ALLRED;
                  timer_reg <= '0;
               end
            endcase
         end
      end
   end

   assign PHASE = phase_reg;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi: reset, idle hold, skip, gap/max-out, round-robin,
// EN freeze and reset during yellow, with lamp run lengths counted in clk cycles (EN=1 => ticks).
module tb_traffic_light_multi;

   logic       clk = 1'b0;
   logic       R   = 1'b1;
   logic       EN  = 1'b1;
   logic [3:0] C   = 4'b0000;
   logic [3:0] RED, GRN, YEL;
   logic [1:0] PHASE;

   int n_cmp = 0;
   int n_bad = 0;
   bit rr_mode = 1'b0;

   traffic_light_multi #(
      .NUM_DIR(4), .CNT_W(8), .T_MIN_GREEN(4), .T_MAX_GREEN(8), .T_YELLOW(2), .T_ALLRED(1)
   ) dut (
      .clk(clk), .R(R), .EN(EN), .C(C), .RED(RED), .GRN(GRN), .YEL(YEL), .PHASE(PHASE)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One clk, then sample 1 ns later; in round-robin mode the serving approach's sensor is masked.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rr_mode) C = 4'hF & ~(4'b0001 << PHASE);
   endtask

   task automatic do_reset();
      R = 1'b1;
      C = 4'b0000;
      tick();
      tick();
      R = 1'b0;
   endtask

   // Counts consecutive cycles showing the lamp pattern (g, y, rest red), bounded.
   task automatic measure(input logic [3:0] g, input logic [3:0] y, output int len);
      len = 0;
      while (GRN === g && YEL === y && RED === ~(g | y) && len < 300) begin
         len++;
         tick();
      end
   endtask

   task automatic test_reset();
      R = 1'b1; EN = 1'b1; C = 4'b0000;
      tick();
      n_cmp++; if (RED !== 4'b1111) begin n_bad++; $display("FAIL reset_red: got %b want 1111", RED); end
      n_cmp++; if (GRN !== 4'b0000) begin n_bad++; $display("FAIL reset_grn: got %b want 0000", GRN); end
      n_cmp++; if (YEL !== 4'b0000) begin n_bad++; $display("FAIL reset_yel: got %b want 0000", YEL); end
      n_cmp++; if (PHASE !== 2'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", PHASE); end
      tick();
      R = 1'b0;
      tick();
      n_cmp++; if (RED !== 4'b1111) begin n_bad++; $display("FAIL first_tick_red: got %b want 1111", RED); end
      tick();
      n_cmp++; if (GRN !== 4'b0001) begin n_bad++; $display("FAIL startup_grn: got %b want 0001", GRN); end
      n_cmp++; if (PHASE !== 2'd0) begin n_bad++; $display("FAIL startup_phase: got %0d want 0", PHASE); end
      $display("test_reset done: RED=%b GRN=%b PHASE=%0d", RED, GRN, PHASE);
   endtask

   task automatic test_idle_hold();
      int bad_cycles = 0;
      C = 4'b0000;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (GRN !== 4'b0001 || YEL !== 4'b0000 || RED !== 4'b1110) bad_cycles++;
      end
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad_cycles); end
      n_cmp++; if (PHASE !== 2'd0) begin n_bad++; $display("FAIL idle_phase: got %0d want 0", PHASE); end
      $display("test_idle_hold done: bad_cycles=%0d", bad_cycles);
   endtask

   task automatic test_skip();
      int len;
      do_reset();
      tick();
      C = 4'b0100;
      tick();
      C = 4'b0000;
      measure(4'b0001, 4'b0000, len);
      n_cmp++; if (len !== 4) begin n_bad++; $display("FAIL skip_green_len: got %0d want 4", len); end
      measure(4'b0000, 4'b0001, len);
      n_cmp++; if (len !== 2) begin n_bad++; $display("FAIL skip_yellow_len: got %0d want 2", len); end
      measure(4'b0000, 4'b0000, len);
      n_cmp++; if (len !== 1) begin n_bad++; $display("FAIL skip_allred_len: got %0d want 1", len); end
      n_cmp++; if (GRN !== 4'b0100) begin n_bad++; $display("FAIL skip_grn: got %b want 0100", GRN); end
      n_cmp++; if (PHASE !== 2'd2) begin n_bad++; $display("FAIL skip_phase: got %0d want 2", PHASE); end
      $display("test_skip done: GRN=%b PHASE=%0d", GRN, PHASE);
   endtask

   task automatic test_max_out();
      int len;
      do_reset();
      tick();
      C = 4'b1001;
      tick();
      C = 4'b0001;
      measure(4'b0001, 4'b0000, len);
      n_cmp++; if (len !== 8) begin n_bad++; $display("FAIL maxout_green_len: got %0d want 8", len); end
      measure(4'b0000, 4'b0001, len);
      n_cmp++; if (len !== 2) begin n_bad++; $display("FAIL maxout_yellow_len: got %0d want 2", len); end
      measure(4'b0000, 4'b0000, len);
      n_cmp++; if (len !== 1) begin n_bad++; $display("FAIL maxout_allred_len: got %0d want 1", len); end
      n_cmp++; if (GRN !== 4'b1000) begin n_bad++; $display("FAIL maxout_grn: got %b want 1000", GRN); end
      n_cmp++; if (PHASE !== 2'd3) begin n_bad++; $display("FAIL maxout_phase: got %0d want 3", PHASE); end
      C = 4'b0000;
      $display("test_max_out done: GRN=%b PHASE=%0d", GRN, PHASE);
   endtask

   task automatic test_gap_out();
      int len;
      do_reset();
      tick();
      C = 4'b1001;
      tick();
      C = 4'b0001;
      tick();
      tick();
      tick();
      n_cmp++; if (GRN !== 4'b0001) begin n_bad++; $display("FAIL gap_pre_grn: got %b want 0001", GRN); end
      C = 4'b0000;
      measure(4'b0001, 4'b0000, len);
      n_cmp++; if (len !== 2) begin n_bad++; $display("FAIL gap_tail_len: got %0d want 2", len); end
      n_cmp++; if (YEL !== 4'b0001) begin n_bad++; $display("FAIL gap_yel: got %b want 0001", YEL); end
      $display("test_gap_out done: YEL=%b", YEL);
   endtask

   task automatic test_round_robin();
      int len;
      logic [3:0] g;
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      rr_mode = 1'b1;
      C = 4'b1110;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         g = 4'b0001 << order[i];
         measure(g, 4'b0000, len);
         n_cmp++; if (len !== 4) begin n_bad++; $display("FAIL rr_green_%0d: got %0d cycles of %b want 4", i, len, g); end
         measure(4'b0000, g, len);
         n_cmp++; if (len !== 2) begin n_bad++; $display("FAIL rr_yellow_%0d: got %0d want 2", i, len); end
         measure(4'b0000, 4'b0000, len);
         $display("test_round_robin green %0d on approach %0d", i, order[i]);
      end
      rr_mode = 1'b0;
      C = 4'b0000;
   endtask

   task automatic test_en_freeze();
      int len;
      int bad_cycles = 0;
      do_reset();
      tick();
      C = 4'b0100;
      tick();
      C = 4'b0000;
      measure(4'b0001, 4'b0000, len);
      n_cmp++; if (YEL !== 4'b0001) begin n_bad++; $display("FAIL freeze_start_yel: got %b want 0001", YEL); end
      EN = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (YEL !== 4'b0001 || GRN !== 4'b0000 || RED !== 4'b1110) bad_cycles++;
      end
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL freeze_hold: got %0d bad cycles want 0", bad_cycles); end
      EN = 1'b1;
      tick();
      n_cmp++; if (YEL !== 4'b0001) begin n_bad++; $display("FAIL freeze_resume_yel: got %b want 0001", YEL); end
      tick();
      n_cmp++; if (RED !== 4'b1111) begin n_bad++; $display("FAIL freeze_resume_red: got %b want 1111", RED); end
      $display("test_en_freeze done: bad_cycles=%0d RED=%b", bad_cycles, RED);
   endtask

   task automatic test_reset_mid_yellow();
      int len;
      int bad_cycles = 0;
      do_reset();
      tick();
      C = 4'b0100;
      tick();
      C = 4'b0000;
      measure(4'b0001, 4'b0000, len);
      C = 4'b1000;
      R = 1'b1;
      tick();
      n_cmp++; if (RED !== 4'b1111) begin n_bad++; $display("FAIL midrst_red: got %b want 1111", RED); end
      n_cmp++; if (YEL !== 4'b0000) begin n_bad++; $display("FAIL midrst_yel: got %b want 0000", YEL); end
      n_cmp++; if (PHASE !== 2'd0) begin n_bad++; $display("FAIL midrst_phase: got %0d want 0", PHASE); end
      R = 1'b0;
      C = 4'b0000;
      tick();
      tick();
      n_cmp++; if (GRN !== 4'b0001) begin n_bad++; $display("FAIL midrst_grn: got %b want 0001", GRN); end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (GRN !== 4'b0001 || YEL !== 4'b0000) bad_cycles++;
      end
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL midrst_dem_cleared: got %0d bad cycles want 0", bad_cycles); end
      $display("test_reset_mid_yellow done: GRN=%b bad_cycles=%0d", GRN, bad_cycles);
   endtask

   initial begin
      test_reset();
      test_idle_hold();
      test_skip();
      test_max_out();
      test_gap_out();
      test_round_robin();
      test_en_freeze();
      test_reset_mid_yellow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
